// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the UART program loader.
//               rx_state_t   - UART receiver FSM states
//               byte_phase_t - which half of an instruction word is expected
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } byte_phase_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver (8E1 when LOADER_PARITY_EN is defined).
//               rx is double-flopped before use. The sample-point outputs are
//               decodes of registered state, asserted in the cycle the stop
//               (or parity) bit is sampled; the parent registers them.
// Ports       : clk, reset (async active-low), i_rx (serial in, idles high)
//               o_byte_valid  - stop bit sampled high, o_byte_data is good
//               o_byte_data   - received byte, LSB first on the wire
//               o_frame_err   - stop bit sampled low
//               o_parity_err  - even-parity mismatch (LOADER_PARITY_EN only)
//               o_busy        - FSM not in IDLE
// Macro       : LOADER_PARITY_EN - adds the PARITY state and o_parity_err
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
`ifdef LOADER_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       c_last_bit  = 3'(UART_DATA_BITS - 1);

    logic             r_sync1;
    logic             r_rx_s;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
`ifdef LOADER_PARITY_EN
    logic             r_par_bad;
`endif

    logic w_tick;
    logic w_stop_sample;

    assign w_tick        = (r_clk_cnt == c_bit_last);
    assign w_stop_sample = (r_state == STOP) && w_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef LOADER_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            case (r_state)
                IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
`ifdef LOADER_PARITY_EN
                    r_par_bad <= 1'b0;
`endif
                    if (!r_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects glitches on the line.
                    if (r_clk_cnt == c_half_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? IDLE : DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == c_last_bit) begin
`ifdef LOADER_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
`ifdef LOADER_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_par_bad <= r_rx_s ^ (^r_shift);
                        r_state   <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_byte_data = r_shift;
    assign o_frame_err = w_stop_sample && !r_rx_s;
    assign o_busy      = (r_state != IDLE);
`ifdef LOADER_PARITY_EN
    // A parity failure discards the byte but the stop bit is still checked.
    assign o_byte_valid = w_stop_sample && r_rx_s && !r_par_bad;
    assign o_parity_err = (r_state == PARITY) && w_tick && (r_rx_s ^ (^r_shift));
`else
    assign o_byte_valid = w_stop_sample && r_rx_s;
`endif

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Serial program loader. Pairs of UART bytes are packed into
//               DATA_WIDTH-bit instruction words and written to sequential
//               program-RAM addresses starting at 0.
// Ports       : clk, reset (async active-low), rx (UART in)
//               program_write   - 1-cycle write strobe
//               program_cmd     - assembled word, held until next write
//               program_address - address of the current/last write
//               busy            - UART frame in progress
//               done            - sticky, last address has been written
//               frame_error     - 1-cycle pulse on a low stop bit
//               parity_error    - 1-cycle pulse on parity mismatch
//                                 (LOADER_PARITY_EN only)
// Macro       : LOADER_PARITY_EN - enables even parity on each UART frame
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT      = 434,
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter int TIMEOUT_BITS      = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] program_address,
    output logic                  busy,
    output logic                  done,
`ifdef LOADER_PARITY_EN
    output logic                  parity_error,
`endif
    output logic                  frame_error
);

    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TO_CYCLES - 1);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;
    logic       w_parity_err;
    logic       w_busy;
    logic       w_timeout;
    logic       w_unused_bits;

    byte_phase_t           r_phase;
    logic [7:0]            r_low_byte;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TO_W-1:0]       r_idle_cnt;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_cmd;
    logic [ADDR_WIDTH-1:0] r_address;
    logic                  r_done;
    logic                  r_frame_error;
`ifdef LOADER_PARITY_EN
    logic                  r_parity_error;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err),
`ifdef LOADER_PARITY_EN
        .o_parity_err (w_parity_err),
`endif
        .o_busy       (w_busy)
    );

`ifndef LOADER_PARITY_EN
    assign w_parity_err = 1'b0;
`endif

    // Upper bits of the high byte are discarded when DATA_WIDTH < 16.
    assign w_unused_bits = &{1'b0, w_byte_data};

    // A half word left waiting too long on an idle line is abandoned.
    assign w_timeout = (r_phase == HIGH) && !w_busy && (r_idle_cnt == c_to_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase        <= LOW;
            r_low_byte     <= '0;
            r_addr         <= '0;
            r_idle_cnt     <= '0;
            r_write        <= 1'b0;
            r_cmd          <= '0;
            r_address      <= '0;
            r_done         <= 1'b0;
            r_frame_error  <= 1'b0;
`ifdef LOADER_PARITY_EN
            r_parity_error <= 1'b0;
`endif
        end else begin
            r_write        <= 1'b0;
            r_frame_error  <= w_frame_err;
`ifdef LOADER_PARITY_EN
            r_parity_error <= w_parity_err;
`endif

            if (w_busy || (r_phase == LOW) || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + TO_W'(1);
            end

            if (w_frame_err || w_parity_err || w_timeout) begin
                r_phase <= LOW;
            end else if (w_byte_valid && !r_done) begin
                if (r_phase == LOW) begin
                    r_low_byte <= w_byte_data;
                    r_phase    <= HIGH;
                end else begin
                    r_cmd     <= {w_byte_data[DATA_WIDTH-9:0], r_low_byte};
                    r_address <= r_addr;
                    r_write   <= 1'b1;
                    r_addr    <= r_addr + ADDR_WIDTH'(1);
                    r_phase   <= LOW;
                    if (r_addr == {ADDR_WIDTH{1'b1}}) begin
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign program_write   = r_write;
    assign program_cmd     = r_cmd;
    assign program_address = r_address;
    assign busy            = w_busy;
    assign done            = r_done;
    assign frame_error     = r_frame_error;
`ifdef LOADER_PARITY_EN
    assign parity_error    = r_parity_error;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader with
//               CLKS_PER_BIT=4 and TIMEOUT_BITS=2 (12-bit words, 8-bit address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int CPB = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rx    = 1'b1;
    logic        program_write;
    logic [11:0] program_cmd;
    logic [7:0]  program_address;
    logic        busy;
    logic        done;
    logic        frame_error;
`ifdef LOADER_PARITY_EN
    logic        parity_error;
`endif

    program_loader #(
        .CLKS_PER_BIT      (CPB),
        .ADDR_WIDTH        (8),
        .INSTRUCTION_WIDTH (4),
        .TIMEOUT_BITS      (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .program_write   (program_write),
        .program_cmd     (program_cmd),
        .program_address (program_address),
        .busy            (busy),
        .done            (done),
`ifdef LOADER_PARITY_EN
        .parity_error    (parity_error),
`endif
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor, sampled on the falling edge.
    int         wr_cnt   = 0;
    int         dbl_wr   = 0;
    int         fe_cnt   = 0;
    int         fe_long  = 0;
    logic [11:0] last_cmd  = '0;
    logic [7:0]  last_addr = '0;
    logic       prev_wr  = 1'b0;
    logic       prev_fe  = 1'b0;
    logic       saw_busy = 1'b0;

    always @(negedge clk) begin
        if (program_write) begin
            wr_cnt++;
            last_cmd  = program_cmd;
            last_addr = program_address;
            if (prev_wr) dbl_wr++;
        end
        if (frame_error) begin
            if (prev_fe) fe_long++;
            else fe_cnt++;
        end
        if (busy) saw_busy = 1'b1;
        prev_wr = program_write;
        prev_fe = frame_error;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef LOADER_PARITY_EN
        rx = ^d;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi);
        send_byte(lo, 1'b1);
        send_byte(hi, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    int w0;
    int f0;

    initial begin
        // ---------------- reset values
        #1;
        check("rst_write", program_write, 0);
        check("rst_cmd",   program_cmd,   0);
        check("rst_addr",  program_address, 0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_ferr",  frame_error, 0);
        do_reset();

        // ---------------- two words back to back
        send_word(8'h5A, 8'h03);
        check("w1_count", wr_cnt, 1);
        check("w1_cmd",   last_cmd, 12'h35A);
        check("w1_addr",  last_addr, 8'h00);
        send_word(8'hFF, 8'h0F);
        check("w2_count", wr_cnt, 2);
        check("w2_cmd",   last_cmd, 12'hFFF);
        check("w2_addr",  last_addr, 8'h01);
        check("strobe_1cycle", dbl_wr, 0);
        repeat (10) @(negedge clk);
        check("hold_cmd",  program_cmd, 12'hFFF);
        check("hold_addr", program_address, 8'h01);
        check("hold_wr",   program_write, 0);

        // ---------------- upper nibble of high byte ignored
        send_word(8'h01, 8'hF2);
        check("nib_cmd",  last_cmd, 12'h201);
        check("nib_addr", last_addr, 8'h02);

        // ---------------- frame error resets phase
        do_reset();
        w0 = wr_cnt;
        f0 = fe_cnt;
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b0);
        repeat (6) @(negedge clk);
        check("fe_pulse",   fe_cnt - f0, 1);
        check("fe_width",   fe_long, 0);
        check("fe_nowrite", wr_cnt - w0, 0);
        send_word(8'h33, 8'h04);
        check("fe_next_cnt",  wr_cnt - w0, 1);
        check("fe_next_cmd",  last_cmd, 12'h433);
        check("fe_next_addr", last_addr, 8'h00);

        // ---------------- false start glitch
        do_reset();
        w0 = wr_cnt;
        f0 = fe_cnt;
        saw_busy = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_saw_busy", saw_busy, 1);
        check("glitch_busy",     busy, 0);
        repeat (10) @(negedge clk);
        check("glitch_nowrite", wr_cnt - w0, 0);
        check("glitch_noerr",   fe_cnt - f0, 0);
        send_word(8'h5A, 8'h03);
        check("glitch_next_cmd",  last_cmd, 12'h35A);
        check("glitch_next_addr", last_addr, 8'h00);

        // ---------------- timeout drops a half word
        do_reset();
        w0 = wr_cnt;
        send_byte(8'h11, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        send_word(8'h22, 8'h01);
        check("to_count", wr_cnt - w0, 1);
        check("to_cmd",   last_cmd, 12'h122);
        check("to_addr",  last_addr, 8'h00);

        // ---------------- fill all addresses
        do_reset();
        w0 = wr_cnt;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'(i);
            hi = {4'hC, lo[3:0]};
            send_word(lo, hi);
            check("fill_cmd",  last_cmd,  {lo[3:0], lo});
            check("fill_addr", last_addr, lo);
            if (i == 254) check("fill_done_early", done, 0);
        end
        check("fill_count", wr_cnt - w0, 256);
        check("fill_done",  done, 1);
        send_word(8'hAB, 8'h0C);
        check("after_done_nowrite", wr_cnt - w0, 256);
        check("after_done_addr",    program_address, 8'hFF);
        check("after_done_cmd",     program_cmd, 12'hFFF);
        check("after_done_sticky",  done, 1);
        f0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        repeat (6) @(negedge clk);
        check("after_done_ferr", fe_cnt - f0, 1);

        // ---------------- reset mid-byte
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_write", program_write, 0);
        check("mid_rst_cmd",   program_cmd, 0);
        check("mid_rst_addr",  program_address, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_done",  done, 0);
        check("mid_rst_ferr",  frame_error, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound on run length.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Serial UART program loader. It receives 8N1 bytes on `rx`, packs byte pairs into DATA_WIDTH-bit instruction words, and drives the text-memory write port: `program_write`, `program_cmd` and the write address.
- Sits between the board UART pin and the processor's program RAM.
- Writes sequential addresses from 0 and flags completion when the last address has been written.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_WIDTH, 8, program memory address width.
- INSTRUCTION_WIDTH, 4, opcode field width.
- DATA_WIDTH, ADDR_WIDTH + INSTRUCTION_WIDTH, instruction word width; legal range 9..16.
- TIMEOUT_BITS, 20, idle bit periods after which a half-received word is dropped.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, idles high, asynchronous to clk.
- program_write  out  1  one-cycle write strobe to program RAM.
- program_cmd  out  DATA_WIDTH  assembled instruction word.
- program_address  out  ADDR_WIDTH  write address for the current strobe.
- busy  out  1  high while a frame is being received.
- done  out  1  sticky; set after address 2^ADDR_WIDTH-1 is written.
- frame_error  out  1  one-cycle pulse when a stop bit is sampled low.

Behaviour:
- Reset values (reset low, asynchronous): all outputs 0, byte phase = LOW, FSM = IDLE, address counter 0.
- Input conditioning: `rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized value.
- FSM states and transitions:
  - IDLE → START on synchronized rx = 0.
  - START: count CLKS_PER_BIT/2. If rx = 1 at the mid-bit sample → IDLE (false start, no output). Otherwise → DATA.
  - DATA: 8 bits, LSB first, each sampled every CLKS_PER_BIT cycles → STOP (or PARITY if the macro is defined).
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx = 1: byte valid.
    - rx = 0: frame_error pulses 1 cycle, byte discarded, byte phase forced to LOW.
  - STOP → IDLE in both cases.
- busy is high in every state except IDLE.
- Byte assembly:
  - Phase LOW: the valid byte is stored as word[7:0]; phase → HIGH.
  - Phase HIGH: the word is {byte[DATA_WIDTH-9:0], low_byte}; byte bits above DATA_WIDTH-9 are ignored; phase → LOW.
- Write timing:
  - program_write asserts for exactly 1 cycle, in the cycle after the stop-bit sample of the HIGH byte.
  - program_cmd and program_address are valid in that cycle and held until the next write.
  - The address counter increments after the strobe.
  - program_address shows the address actually written.
- Completion: a write to address 2^ADDR_WIDTH-1 sets done.
  - While done is high, received bytes are ignored: no strobe, no address change.
  - frame_error still reports.
  - done clears only on reset.
- Timeout: in phase HIGH with the FSM in IDLE for TIMEOUT_BITS×CLKS_PER_BIT cycles, phase → LOW and the partial word is dropped. The idle counter clears on any start bit.
- Simultaneous events: a new start bit during the write cycle is accepted normally, since the FSM is already in IDLE.
- Reset mid-frame: immediate return to reset values; the partial byte and word are lost.

Optional Feature:
- Macro: LOADER_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - On mismatch, the byte is discarded, phase → LOW, and an extra output `parity_error` (1 bit, reset 0) pulses 1 cycle.
  - The stop bit is still checked.
- Undefined: no PARITY state and no parity_error port; frames are 10 bits.

Decomposition:
- Package loader_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - byte_phase_t enum (LOW, HIGH).
  - Constant UART_DATA_BITS = 8.
- Sub-module uart_rx_byte:
  - Contains the synchronizer, FSM and bit/cycle counters.
  - Outputs byte_valid, byte_data[7:0], frame_err (and parity_err).
- program_loader instantiates uart_rx_byte and adds the assembler, address counter, timeout and done logic.

Test Plan:
Benches use CLKS_PER_BIT=4 and TIMEOUT_BITS=2.
- Send 0x5A, 0x03, then 0xFF, 0x0F → two 1-cycle strobes: cmd 12'h35A at addr 0x00, then 12'hFFF at addr 0x01.
- Send 0x01, 0xF2 → cmd 12'h201 (upper nibble of the high byte ignored).
- Send 0x10, then 0x20 with stop bit 0 → frame_error pulse, no strobe. Then send 0x33, 0x04 → cmd 12'h433 at addr 0x00.
- Drive rx low for 1 cycle → no byte, no error, busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Send 0x11, idle 3 bit periods, then send 0x22, 0x01 → single strobe, cmd 12'h122.
- Send 256 words → done set after addr 0xFF, and a 257th word causes no strobe. Then pull reset low mid-byte → all outputs 0 immediately.
